// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and its neighbours:
// FSM state encoding, transfer status codes, keyboard command bytes and a
// helper that builds the on-wire frame for a command byte.
// ---------------------------------------------------------------------------
package ps2_pkg;

   // Transmitter FSM states
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_WAIT_EDGE = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   // Transfer status reported with tx_done
   typedef logic [1:0] tx_status_t;
   localparam tx_status_t TX_OK      = 2'b00;
   localparam tx_status_t TX_NOACK   = 2'b01;
   localparam tx_status_t TX_TIMEOUT = 2'b10;

   // Keyboard command bytes
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;

   // Frame shifted out after the start bit: {stop, odd parity, data}.
   // Bit 0 is the first data bit on the wire.
   function automatic logic [9:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Brings the asynchronous PS/2 clock and data pins into the CLOCK_50 domain
// with 2-FF synchronizers and flags falling edges of the PS/2 clock.
//   CLOCK_50   in   system clock
//   resetn     in   synchronous, active-low reset
//   i_clk_pin  in   raw PS2_CLK pin
//   i_dat_pin  in   raw PS2_DAT pin
//   o_clk_s    out  synchronized PS2_CLK level
//   o_dat_s    out  synchronized PS2_DAT level
//   o_clk_fall out  one-cycle pulse on a synchronized PS2_CLK falling edge
// ---------------------------------------------------------------------------
module ps2_sync_edge (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic i_clk_pin,
   input  logic i_dat_pin,
   output logic o_clk_s,
   output logic o_dat_s,
   output logic o_clk_fall
);

   logic r_clk_s1, r_clk_s2, r_clk_s3;
   logic r_dat_s1, r_dat_s2;

   // Reset to the idle-high bus level so no spurious edge follows reset.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_s3 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= i_clk_pin;
         r_clk_s2 <= r_clk_s1;
         r_clk_s3 <= r_clk_s2;
         r_dat_s1 <= i_dat_pin;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign o_clk_s    = r_clk_s2;
   assign o_dat_s    = r_dat_s2;
   // r_clk_s3 is the previous synchronized level: high then low is a fall.
   assign o_clk_fall = ~r_clk_s2 & r_clk_s3;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// using the open-drain handshake: inhibit the clock, request-to-send with
// a start bit, then present data/parity/stop on device clock falls and
// sample the device ACK. Only output enables are produced; the top level
// builds the tri-states (oe=1 pulls the line low).
//   CLOCK_50    in   50 MHz system clock
//   resetn      in   synchronous, active-low reset
//   tx_data     in   command byte
//   tx_valid    in   request, accepted when tx_valid & tx_ready
//   tx_ready    out  high only while idle
//   busy        out  high while a transfer is in progress
//   ps2_clk_in  in   raw PS2_CLK pin
//   ps2_dat_in  in   raw PS2_DAT pin
//   ps2_clk_oe  out  pull PS2_CLK low
//   ps2_dat_oe  out  pull PS2_DAT low
//   tx_done     out  one-cycle pulse at the end of each accepted transfer
//   tx_status   out  00 ok, 01 no ACK, 10 timeout; held until next tx_done
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_TIMEOUT  = 750000,
   parameter int BIT_TIMEOUT    = 100000,
   parameter int CNT_W          = 20
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       tx_done,
   output logic [1:0] tx_status
);

   // Terminal counts: the counter runs 0..N-1 for an N-cycle interval.
   localparam logic [CNT_W-1:0] L_INH   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_START = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_BIT   = CNT_W'(BIT_TIMEOUT - 1);

   logic             w_clk_s, w_dat_s, w_fall;
   logic [CNT_W-1:0] w_edge_limit;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit_cnt;
   logic [9:0]       r_shreg;
   logic             r_clk_oe, r_dat_oe;
   logic [1:0]       r_ack_status;
   logic [1:0]       r_tx_status;

   ps2_sync_edge u_sync (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .i_clk_pin  (ps2_clk_in),
      .i_dat_pin  (ps2_dat_in),
      .o_clk_s    (w_clk_s),
      .o_dat_s    (w_dat_s),
      .o_clk_fall (w_fall)
   );

   // The device may take much longer to start clocking than between bits.
   assign w_edge_limit = (r_bit_cnt == 4'd0) ? L_START : L_BIT;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_bit_cnt    <= 4'd0;
         r_clk_oe     <= 1'b0;
         r_dat_oe     <= 1'b0;
         r_ack_status <= TX_OK;
         r_tx_status  <= TX_OK;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (tx_valid) begin
                  r_state   <= ST_INHIBIT;
                  r_cnt     <= '0;
                  r_bit_cnt <= 4'd0;
                  r_clk_oe  <= 1'b1;
                  r_dat_oe  <= 1'b0;
               end
            end
            ST_INHIBIT: begin
               if (r_cnt == L_INH) begin
                  r_state  <= ST_REQ;
                  r_cnt    <= '0;
                  r_dat_oe <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_REQ: begin
               // Release the clock, keep DAT low as the start bit.
               r_state  <= ST_WAIT_EDGE;
               r_cnt    <= '0;
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b1;
            end
            ST_WAIT_EDGE: begin
               // A fall in the same cycle as expiry takes precedence.
               if (w_fall) begin
                  r_cnt     <= '0;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd10) begin
                     r_ack_status <= w_dat_s ? TX_NOACK : TX_OK;
                     r_state      <= ST_WAIT_IDLE;
                     r_dat_oe     <= 1'b0;
                  end else begin
                     r_dat_oe <= ~r_shreg[0];
                  end
               end else if (r_cnt == w_edge_limit) begin
                  r_state     <= ST_DONE;
                  r_tx_status <= TX_TIMEOUT;
                  r_dat_oe    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_WAIT_IDLE: begin
               if (w_clk_s && w_dat_s) begin
                  r_state     <= ST_DONE;
                  r_tx_status <= r_ack_status;
               end else if (r_cnt == L_BIT) begin
                  r_state     <= ST_DONE;
                  r_tx_status <= TX_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
            end
         endcase
      end
   end

   // Frame shift register: loaded on accept, shifted on each fall that
   // presents a new bit. Pure datapath, so no reset.
   always_ff @(posedge CLOCK_50) begin
      if (r_state == ST_IDLE && tx_valid) begin
         r_shreg <= ps2_frame(tx_data);
      end else if (r_state == ST_WAIT_EDGE && w_fall && r_bit_cnt != 4'd10) begin
         r_shreg <= {1'b1, r_shreg[9:1]};
      end
   end

   assign tx_ready   = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign tx_done    = (r_state == ST_DONE);
   assign tx_status  = r_tx_status;
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;

endmodule
